ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the sending half of the keyboard link whose receive half is ps2ctrlr.

---
 rtl/ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device transmitter. Sends one command byte to the
//             keyboard using the request-to-send sequence: inhibit the clock,
//             pull data low for the start bit, release the clock, then shift
//             the data/parity/stop bits out on device clock falling edges and
//             sample the device ACK.
//  Ports    : CLOCK_50            system clock (posedge)
//             reset               asynchronous, active-high
//             tx_data/tx_valid    command byte + request (accepted when ready)
//             tx_ready            idle, able to accept a byte
//             PS2_CLK/PS2_DAT     raw pad levels of the PS/2 lines
//             ps2_clk_oe/_dat_oe  1 = pull the corresponding line low
//             tx_done/tx_nack     frame complete pulse, NACK flag
//             tx_err              timeout abort pulse
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_err
);

    localparam int c_PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_FLT_W  = $clog2(FILTER_LEN + 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_INHIBIT  = 3'd1;
    localparam logic [2:0] c_S_REQ      = 3'd2;
    localparam logic [2:0] c_S_BITS     = 3'd3;
    localparam logic [2:0] c_S_ACK      = 3'd4;
    localparam logic [2:0] c_S_WAITIDLE = 3'd5;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = clock line, bit 1 = data line.
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {PS2_DAT, PS2_CLK};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic               r_s1;
        logic               r_s2;
        logic               r_level;
        logic [c_FLT_W-1:0] r_cnt;

        // The filtered level only follows the synchronized input after it
        // has disagreed for FILTER_LEN consecutive samples.
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_level <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_FLT_W'(FILTER_LEN - 1)) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[g] = r_level;
    end

    logic r_clk_filt_d;
    logic w_fall;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= w_filt[0];
        end
    end

    assign w_fall = r_clk_filt_d & ~w_filt[0];

    // ------------------------------------------------------------------
    // Control signals
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [c_PH_W-1:0] r_ph_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [9:0]        r_frame;
    logic [3:0]        r_idx;
    logic              r_dat_bit;
    logic              r_ack_dat;
    logic              r_done;
    logic              r_nack;
    logic              r_err;

    logic w_accept;
    logic w_ph_last;
    logic w_to_active;
    logic w_timeout;
    logic w_line_idle;
    logic w_enter_bits;

    assign w_accept    = tx_valid && (r_state == c_S_IDLE);
    assign w_ph_last   = ((r_state == c_S_INHIBIT) && (r_ph_cnt == c_PH_W'(INHIBIT_CYCLES - 1))) ||
                         ((r_state == c_S_REQ)     && (r_ph_cnt == c_PH_W'(SETUP_CYCLES - 1)));
    assign w_to_active = (r_state == c_S_BITS) || (r_state == c_S_ACK) || (r_state == c_S_WAITIDLE);
    assign w_timeout   = w_to_active && (r_to_cnt >= c_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_line_idle = w_filt[0] & w_filt[1];
    assign w_enter_bits = (r_state == c_S_REQ) && w_ph_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A timeout wins over a fall in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:     if (w_accept) w_next = c_S_INHIBIT;
            c_S_INHIBIT:  if (w_ph_last) w_next = c_S_REQ;
            c_S_REQ:      if (w_ph_last) w_next = c_S_BITS;
            c_S_BITS: begin
                if (w_timeout)                     w_next = c_S_IDLE;
                else if (w_fall && r_idx == 4'd9)  w_next = c_S_ACK;
            end
            c_S_ACK: begin
                if (w_timeout)   w_next = c_S_IDLE;
                else if (w_fall) w_next = c_S_WAITIDLE;
            end
            c_S_WAITIDLE: begin
                if (w_timeout || w_line_idle) w_next = c_S_IDLE;
            end
            default:      w_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Decoded straight from the state register so an async
    // reset releases both lines without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        tx_ready   = 1'b0;
        case (r_state)
            c_S_IDLE:    tx_ready = 1'b1;
            c_S_INHIBIT: ps2_clk_oe = 1'b1;
            c_S_REQ: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
            end
            c_S_BITS:    ps2_dat_oe = r_dat_bit;
            default: begin
                ps2_clk_oe = 1'b0;
                ps2_dat_oe = 1'b0;
            end
        endcase
    end

    assign tx_done = r_done;
    assign tx_nack = r_nack;
    assign tx_err  = r_err;

    // ------------------------------------------------------------------
    // Datapath: frame latch, phase/timeout counters, bit shifting, status.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_frame   <= '0;
            r_ph_cnt  <= '0;
            r_to_cnt  <= '0;
            r_idx     <= '0;
            r_dat_bit <= 1'b0;
            r_ack_dat <= 1'b1;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            // Frame is {stop, odd parity, data}; shifted out LSB first.
            if (w_accept) begin
                r_frame  <= {1'b1, ~^tx_data, tx_data};
                r_ph_cnt <= '0;
            end else if ((r_state == c_S_INHIBIT) || (r_state == c_S_REQ)) begin
                if (w_ph_last) begin
                    r_ph_cnt <= '0;
                end else if (r_ph_cnt != c_PH_W'(c_PH_MAX)) begin
                    r_ph_cnt <= r_ph_cnt + 1'b1;
                end
            end

            if (w_enter_bits || (w_to_active && w_fall)) begin
                r_to_cnt <= '0;
            end else if (w_to_active && (r_to_cnt != c_TO_W'(TIMEOUT_CYCLES))) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Start bit stays on the line until the device's first fall.
            if (w_enter_bits) begin
                r_idx     <= '0;
                r_dat_bit <= 1'b1;
            end else if ((r_state == c_S_BITS) && w_fall && !w_timeout) begin
                r_dat_bit <= ~r_frame[r_idx];
                r_idx     <= r_idx + 4'd1;
            end

            // The ACK sample is held privately so tx_nack only changes
            // together with tx_done.
            if ((r_state == c_S_ACK) && w_fall && !w_timeout) begin
                r_ack_dat <= w_filt[1];
            end

            if ((r_state == c_S_WAITIDLE) && !w_timeout && w_line_idle) begin
                r_done <= 1'b1;
                r_nack <= r_ack_dat;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a behavioural PS/2
//             device model and a scoreboard of expected frame results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH  = 60;
    localparam int c_SET  = 25;
    localparam int c_TO   = 2000;
    localparam int c_FLT  = 4;
    localparam int c_HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       clk_oe;
    logic       dat_oe;
    logic       tx_done;
    logic       tx_nack;
    logic       tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       pad_clk;
    logic       pad_dat;

    // Open-drain bus: a line is low if either side pulls it.
    assign pad_clk = ~clk_oe & dev_clk;
    assign pad_dat = ~dat_oe & dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_INH),
        .SETUP_CYCLES  (c_SET),
        .TIMEOUT_CYCLES(c_TO),
        .FILTER_LEN    (c_FLT)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .PS2_CLK   (pad_clk),
        .PS2_DAT   (pad_dat),
        .ps2_clk_oe(clk_oe),
        .ps2_dat_oe(dat_oe),
        .tx_done   (tx_done),
        .tx_nack   (tx_nack),
        .tx_err    (tx_err)
    );

    typedef struct {
        bit         is_err;
        bit         nack;
        logic [9:0] frame;   // line level after falls 1..10 (bit 0 = fall 1)
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    int         checks = 0;
    int         errors = 0;
    int         dev_mode = 0;   // 0 ACK, 1 NACK, 2 silent, 3 stop after fall 4
    logic [9:0] dev_cap = '0;
    bit         dev_stopped = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Device model: reacts to the request-to-send (clock released, data low).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !clk_oe && dat_oe) begin
                dev_cap     = '0;
                dev_stopped = 1'b0;
                if (dev_mode == 2) begin
                    while (dat_oe) @(negedge clk);
                end else begin
                    for (int i = 0; i < 10; i++) begin
                        repeat (c_HALF) @(negedge clk);
                        dev_clk = 1'b0;
                        repeat (c_HALF) @(negedge clk);
                        dev_cap[i] = pad_dat;
                        dev_clk = 1'b1;
                        if (dev_mode == 3 && i == 3) begin
                            dev_stopped = 1'b1;
                            break;
                        end
                    end
                    if (dev_mode == 3) begin
                        while (!rst) @(negedge clk);
                        while (rst) @(negedge clk);
                    end else begin
                        repeat (c_HALF / 2) @(negedge clk);
                        if (dev_mode == 0) dev_dat = 1'b0;
                        repeat (c_HALF / 2) @(negedge clk);
                        dev_clk = 1'b0;
                        repeat (c_HALF) @(negedge clk);
                        dev_clk = 1'b1;
                        repeat (4) @(negedge clk);
                        dev_dat = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per tx_done / tx_err pulse.
    always @(negedge clk) begin
        if (!rst && (tx_done || tx_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, tx_done, tx_err}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("pulse_err", {31'd0, tx_err}, {31'd0, e_mon.is_err});
                chk("pulse_done", {31'd0, tx_done}, {31'd0, !e_mon.is_err});
                chk("ready_at_end", {31'd0, tx_ready}, 32'd1);
                if (!e_mon.is_err) begin
                    chk("nack", {31'd0, tx_nack}, {31'd0, e_mon.nack});
                    chk("frame_bits", {22'd0, dev_cap}, {22'd0, e_mon.frame});
                end else begin
                    chk("oe_at_err", {30'd0, clk_oe, dat_oe}, 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("send_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int drise;
        int n;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        chk("rst_pulses", {29'd0, tx_done, tx_nack, tx_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // T1 + T2: 0xED with ACK, plus request timing
        dev_mode = 0;
        sb.push_back('{1'b0, 1'b0, 10'h3ED});
        send(8'hED);
        hi = 0;
        drise = -1;
        @(negedge clk);
        while (clk_oe && hi < 10000) begin
            if (dat_oe && drise < 0) drise = hi;
            hi++;
            @(negedge clk);
        end
        chk("clk_oe_len", hi, c_INH + c_SET);
        chk("dat_oe_rise", drise, c_INH);
        chk("dat_held_at_release", {31'd0, dat_oe}, 32'd1);
        wait_drain(5000);

        // T3: 0x07 with NACK
        dev_mode = 1;
        sb.push_back('{1'b0, 1'b1, 10'h207});
        send(8'h07);
        wait_drain(5000);

        // T4: silent device, timeout
        dev_mode = 2;
        sb.push_back('{1'b1, 1'b0, 10'h000});
        send(8'hAB);
        n = 0;
        while (!clk_oe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        while (clk_oe && n < 2000) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (!tx_err && k < c_TO + 100) begin
            k++;
            @(negedge clk);
        end
        chk("timeout_cycles", k, c_TO);
        chk("timeout_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        wait_drain(5000);

        // T5: request while busy is ignored
        dev_mode = 0;
        sb.push_back('{1'b0, 1'b0, 10'h3FF});
        send(8'hFF);
        repeat (200) @(negedge clk);
        chk("busy_not_ready", {31'd0, tx_ready}, 32'd0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (300) @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_drain(5000);
        repeat (200) @(negedge clk);
        chk("idle_after_ignored", {31'd0, tx_ready}, 32'd1);
        chk("no_extra_frame", {30'd0, clk_oe, dat_oe}, 32'd0);

        // T6: async reset mid-frame, then a clean 0xF4 send
        dev_mode = 3;
        send(8'hED);
        n = 0;
        while (!dev_stopped && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("dev_reached_fall4", {31'd0, dev_stopped}, 32'd1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        chk("async_rst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        dev_mode = 0;
        sb.push_back('{1'b0, 1'b0, 10'h2F4});
        send(8'hF4);
        wait_drain(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
